qduc_sample_feeder: RTL and testbench

- Upstream stage of the quadrature digital upconverter.
- Accepts 16-bit I/Q baseband pairs from the host or DMA side through a valid/ready handshake and buffers them in a small FIFO.
- Presents one I/Q pair per interpolation period (2^RATE_LOG2 clocks) on registered outputs that drive the upconverter's in_i/in_q.
- Handles priming, underflow and enable/disable so the CIC never sees a torn or stale sample.

---
 rtl/qduc_pkg.sv | 16 +
 rtl/qduc_sample_feeder_if.sv | 12 +
 rtl/sample_fifo.sv | 66 ++++++
 rtl/qduc_sample_feeder.sv | 152 +++++++++++++++
 tb/tb_qduc_sample_feeder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qduc_pkg.sv
// Shared constants and state type for the quadrature upconverter and its sample feeder.
// The upconverter imports the same RATE_LOG2, so both dividers always have the same width.
package qduc_pkg;

    localparam int ISZ         = 16;
    localparam int DEPTH_LOG2  = 6;
    localparam int RATE_LOG2   = 8;
    localparam int PRIME_LEVEL = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } feeder_state_e;

endpackage

// File: rtl/qduc_sample_feeder_if.sv
// Valid/ready stream that carries one signed I/Q baseband pair per transfer.
interface qduc_sample_feeder_if;

    logic                            s_valid;
    logic                            s_ready;
    logic signed [qduc_pkg::ISZ-1:0] s_i;
    logic signed [qduc_pkg::ISZ-1:0] s_q;

    modport master (output s_valid, s_i, s_q, input s_ready);
    modport slave  (input s_valid, s_i, s_q, output s_ready);

endinterface

// File: rtl/sample_fifo.sv
// Single-clock circular FIFO with an extra pointer bit for full/empty and an exact registered level.
module sample_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wrEn,
    input  logic [WIDTH-1:0]     wrData,
    input  logic                 rdEn,
    output logic [WIDTH-1:0]     rdData,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   level
);

    localparam logic [ADDR_BITS:0] PtrOne = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [WIDTH-1:0]   mem [2**ADDR_BITS];
    logic [ADDR_BITS:0] wrPtr_q;
    logic [ADDR_BITS:0] rdPtr_q;
    logic [ADDR_BITS:0] level_q;
    logic               wrFire;
    logic               rdFire;

    assign full   = (wrPtr_q[ADDR_BITS] != rdPtr_q[ADDR_BITS]) &&
                    (wrPtr_q[ADDR_BITS-1:0] == rdPtr_q[ADDR_BITS-1:0]);
    assign empty  = (wrPtr_q == rdPtr_q);
    assign wrFire = wrEn && !full && !flush;
    assign rdFire = rdEn && !empty && !flush;
    assign rdData = mem[rdPtr_q[ADDR_BITS-1:0]];
    assign level  = level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (wrFire) begin
                wrPtr_q <= wrPtr_q + PtrOne;
            end
            if (rdFire) begin
                rdPtr_q <= rdPtr_q + PtrOne;
            end
            if (wrFire && !rdFire) begin
                level_q <= level_q + PtrOne;
            end else if (rdFire && !wrFire) begin
                level_q <= level_q - PtrOne;
            end
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem[wrPtr_q[ADDR_BITS-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/qduc_sample_feeder.sv
// Buffers host I/Q pairs and hands one pair to the upconverter per interpolation period,
// with priming, underflow recovery and glitch-free disable.
module qduc_sample_feeder
    import qduc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    qduc_sample_feeder_if.slave   s,
    output logic signed [ISZ-1:0] out_i,
    output logic signed [ISZ-1:0] out_q,
    output logic                  sample_strobe,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underflow,
    output logic                  running
);

    localparam logic [RATE_LOG2-1:0]  DivOne     = {{(RATE_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   PrimeLevel = (DEPTH_LOG2+1)'(PRIME_LEVEL);

    logic [RATE_LOG2-1:0]  divider_q;
    logic                  update;
    feeder_state_e         state_q;
    feeder_state_e         state_d;
    logic signed [ISZ-1:0] outI_q;
    logic signed [ISZ-1:0] outI_d;
    logic signed [ISZ-1:0] outQ_q;
    logic signed [ISZ-1:0] outQ_d;
    logic                  strobe_q;
    logic                  strobe_d;
    logic                  underflow_q;
    logic                  underflow_d;
    logic                  pop;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic [2*ISZ-1:0]      rdData;
    logic [DEPTH_LOG2:0]   fifoLevel;

    sample_fifo #(
        .WIDTH     (2*ISZ),
        .ADDR_BITS (DEPTH_LOG2)
    ) fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .wrEn   (s.s_valid),
        .wrData ({s.s_i, s.s_q}),
        .rdEn   (pop),
        .rdData (rdData),
        .full   (full),
        .empty  (empty),
        .level  (fifoLevel)
    );

    // Free-running in every state so it never drifts from the upconverter's divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider_q <= '0;
        end else begin
            divider_q <= divider_q + DivOne;
        end
    end

    assign update = (divider_q == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            outI_q      <= '0;
            outQ_q      <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            outI_q      <= outI_d;
            outQ_q      <= outQ_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs only ever change on an update event, so the CIC never sees a mid-period step.
    always_comb begin
        state_d     = state_q;
        outI_d      = outI_q;
        outQ_d      = outQ_q;
        strobe_d    = 1'b0;
        underflow_d = underflow_q;
        pop         = 1'b0;
        flush       = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            underflow_d = 1'b0;
            flush       = (state_q != IDLE);
            if (update) begin
                outI_d = '0;
                outQ_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRIME;
                    if (update) begin
                        outI_d = '0;
                        outQ_d = '0;
                    end
                end
                PRIME: begin
                    if (update) begin
                        if (fifoLevel >= PrimeLevel) begin
                            state_d  = RUN;
                            pop      = 1'b1;
                            strobe_d = 1'b1;
                            outI_d   = rdData[2*ISZ-1:ISZ];
                            outQ_d   = rdData[ISZ-1:0];
                        end else begin
                            outI_d = '0;
                            outQ_d = '0;
                        end
                    end
                end
                RUN: begin
                    if (update) begin
                        strobe_d = 1'b1;
                        if (!empty) begin
                            pop    = 1'b1;
                            outI_d = rdData[2*ISZ-1:ISZ];
                            outQ_d = rdData[ISZ-1:0];
                        end else begin
                            outI_d      = '0;
                            outQ_d      = '0;
                            underflow_d = 1'b1;
                            state_d     = PRIME;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign s.s_ready     = !full && !reset;
    assign out_i         = outI_q;
    assign out_q         = outQ_q;
    assign sample_strobe = strobe_q;
    assign level         = fifoLevel;
    assign underflow     = underflow_q;
    assign running       = (state_q == RUN);

endmodule

// File: tb/tb_qduc_sample_feeder.sv
// Directed bench for the sample feeder: streaming order, priming, full, underflow,
// disable and asynchronous reset, with a reference divider for strobe alignment.
module tb_qduc_sample_feeder;
    import qduc_pkg::*;

    localparam int Period  = 2 ** RATE_LOG2;
    localparam int Budget  = Period + 8;

    typedef struct {
        logic                  hasInput;
        logic signed [ISZ-1:0] inI;
        logic signed [ISZ-1:0] inQ;
        logic signed [ISZ-1:0] expI;
        logic signed [ISZ-1:0] expQ;
        logic                  expUnderflow;
        logic                  expRunning;
        logic [DEPTH_LOG2:0]   expLevel;
    } vector_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic signed [ISZ-1:0] out_i;
    logic signed [ISZ-1:0] out_q;
    logic                  sample_strobe;
    logic [DEPTH_LOG2:0]   level;
    logic                  underflow;
    logic                  running;

    logic [RATE_LOG2-1:0]  tbDiv;
    int                    cycleCount = 0;
    int                    testsRun = 0;
    int                    testsFailed = 0;
    vector_t               vectors [21];
    logic                  seen;
    logic                  heldBad;
    int                    strobeCount;
    int                    runCount;
    int                    startCount;

    qduc_sample_feeder_if tbIf ();

    qduc_sample_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .s             (tbIf),
        .out_i         (out_i),
        .out_q         (out_q),
        .sample_strobe (sample_strobe),
        .level         (level),
        .underflow     (underflow),
        .running       (running)
    );

    always #5 clk = ~clk;

    // Reference divider: resets with the DUT and marks where every strobe must land.
    always @(posedge clk or posedge reset) begin
        if (reset) tbDiv <= '0;
        else       tbDiv <= tbDiv + 1'b1;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sample_strobe === 1'b1) checkOutput("strobe_alignment", 32'(tbDiv), 32'sd0);
    end

    task automatic applyStimulus(input logic signed [ISZ-1:0] i, input logic signed [ISZ-1:0] q);
        int waited = 0;
        tbIf.s_valid = 1'b1;
        tbIf.s_i     = i;
        tbIf.s_q     = q;
        while (tbIf.s_ready !== 1'b1 && waited < 2 * Period) begin
            @(posedge clk); #1;
            waited++;
        end
        if (tbIf.s_ready !== 1'b1) checkOutput("push_timeout", 32'(tbIf.s_ready), 32'sd1);
        @(posedge clk); #1;
        tbIf.s_valid = 1'b0;
    endtask

    task automatic pushRange(input int base, input int count);
        for (int n = base; n < base + count; n++) applyStimulus(ISZ'(n), ISZ'(-n));
    endtask

    task automatic waitStrobe(input string name, output logic found);
        found = 1'b0;
        for (int c = 0; c < Budget && !found; c++) begin
            @(posedge clk); #1;
            if (sample_strobe === 1'b1) found = 1'b1;
        end
        checkOutput(name, 32'(found), 32'sd1);
    endtask

    initial begin
        for (int k = 0; k < 20; k++) begin
            vectors[k] = '{1'b1, ISZ'(k + 1), ISZ'(-(k + 1)), ISZ'(k + 1), ISZ'(-(k + 1)),
                           1'b0, 1'b1, (DEPTH_LOG2+1)'(19 - k)};
        end
        vectors[20] = '{1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0};

        reset        = 1'b1;
        enable       = 1'b0;
        tbIf.s_valid = 1'b0;
        tbIf.s_i     = '0;
        tbIf.s_q     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", 32'(tbIf.s_ready), 32'sd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_ready", 32'(tbIf.s_ready), 32'sd1);
        checkOutput("rst_level", 32'(level), 32'sd0);
        checkOutput("rst_out_i", 32'(out_i), 32'sd0);
        checkOutput("rst_out_q", 32'(out_q), 32'sd0);
        checkOutput("rst_strobe", 32'(sample_strobe), 32'sd0);
        checkOutput("rst_underflow", 32'(underflow), 32'sd0);
        checkOutput("rst_running", 32'(running), 32'sd0);

        // Stream 20 pairs with no refill: 20 data strobes, then an underflow strobe.
        enable = 1'b1;
        foreach (vectors[v]) if (vectors[v].hasInput) applyStimulus(vectors[v].inI, vectors[v].inQ);
        foreach (vectors[v]) begin
            waitStrobe($sformatf("vec%0d_strobe", v), seen);
            checkOutput($sformatf("vec%0d_out_i", v), 32'(out_i), 32'(vectors[v].expI));
            checkOutput($sformatf("vec%0d_out_q", v), 32'(out_q), 32'(vectors[v].expQ));
            checkOutput($sformatf("vec%0d_underflow", v), 32'(underflow), 32'(vectors[v].expUnderflow));
            checkOutput($sformatf("vec%0d_running", v), 32'(running), 32'(vectors[v].expRunning));
            checkOutput($sformatf("vec%0d_level", v), 32'(level), 32'(vectors[v].expLevel));
        end

        // Refill after underflow: RUN resumes, sticky flag stays set.
        pushRange(101, 16);
        waitStrobe("refill_strobe", seen);
        checkOutput("refill_out_i", 32'(out_i), 32'sd101);
        checkOutput("refill_out_q", 32'(out_q), -32'sd101);
        checkOutput("refill_running", 32'(running), 32'sd1);
        checkOutput("refill_underflow", 32'(underflow), 32'sd1);
        pushRange(117, 15);
        checkOutput("pre_disable_level", 32'(level), 32'sd30);

        // Disable mid-period: immediate flush, outputs held until the next update.
        enable = 1'b0;
        @(posedge clk); #1;
        checkOutput("disable_level", 32'(level), 32'sd0);
        checkOutput("disable_underflow", 32'(underflow), 32'sd0);
        checkOutput("disable_running", 32'(running), 32'sd0);
        checkOutput("disable_hold_i", 32'(out_i), 32'sd101);
        strobeCount = 0;
        for (int c = 0; c < Budget && tbDiv != 0; c++) begin
            @(posedge clk); #1;
            if (sample_strobe === 1'b1) strobeCount++;
        end
        checkOutput("disable_zero_i", 32'(out_i), 32'sd0);
        checkOutput("disable_zero_q", 32'(out_q), 32'sd0);
        repeat (2 * Period) begin
            @(posedge clk); #1;
            if (sample_strobe === 1'b1) strobeCount++;
        end
        checkOutput("disable_no_strobe", 32'(strobeCount), 32'sd0);

        // Priming: 15 pairs are not enough, the 16th starts RUN.
        pushRange(201, 15);
        checkOutput("prime_level", 32'(level), 32'sd15);
        enable      = 1'b1;
        strobeCount = 0;
        runCount    = 0;
        repeat (4 * Period) begin
            @(posedge clk); #1;
            if (sample_strobe === 1'b1) strobeCount++;
            if (running === 1'b1) runCount++;
        end
        checkOutput("prime_no_strobe", 32'(strobeCount), 32'sd0);
        checkOutput("prime_not_running", 32'(runCount), 32'sd0);
        applyStimulus(ISZ'(216), ISZ'(-216));
        waitStrobe("prime_strobe", seen);
        checkOutput("prime_out_i", 32'(out_i), 32'sd201);
        checkOutput("prime_out_q", 32'(out_q), -32'sd201);
        checkOutput("prime_running", 32'(running), 32'sd1);
        checkOutput("prime_level_after", 32'(level), 32'sd15);

        // Full: 64 pairs, a 65th write is held until the next pop frees a slot.
        enable = 1'b0;
        @(posedge clk); #1;
        checkOutput("full_flushed", 32'(level), 32'sd0);
        pushRange(301, 64);
        checkOutput("full_ready", 32'(tbIf.s_ready), 32'sd0);
        checkOutput("full_level", 32'(level), 32'sd64);
        tbIf.s_valid = 1'b1;
        tbIf.s_i     = ISZ'(365);
        tbIf.s_q     = ISZ'(-365);
        enable       = 1'b1;
        heldBad      = 1'b0;
        seen         = 1'b0;
        for (int c = 0; c < Budget && !seen; c++) begin
            @(posedge clk); #1;
            if (sample_strobe === 1'b1) seen = 1'b1;
            else if (tbIf.s_ready !== 1'b0 || level !== 7'd64) heldBad = 1'b1;
        end
        checkOutput("full_strobe", 32'(seen), 32'sd1);
        checkOutput("full_held", 32'(heldBad), 32'sd0);
        checkOutput("full_pop_out_i", 32'(out_i), 32'sd301);
        checkOutput("full_pop_level", 32'(level), 32'sd63);
        checkOutput("full_pop_ready", 32'(tbIf.s_ready), 32'sd1);
        @(posedge clk); #1;
        tbIf.s_valid = 1'b0;
        checkOutput("full_refill_level", 32'(level), 32'sd64);
        waitStrobe("full_next_strobe", seen);
        checkOutput("full_next_out_q", 32'(out_q), -32'sd302);
        checkOutput("full_next_level", 32'(level), 32'sd63);

        // Asynchronous reset at divider 100, between clock edges.
        for (int c = 0; c < Budget && tbDiv != 8'd100; c++) begin
            @(posedge clk); #1;
        end
        #3 reset = 1'b1;
        #1;
        checkOutput("areset_out_i", 32'(out_i), 32'sd0);
        checkOutput("areset_out_q", 32'(out_q), 32'sd0);
        checkOutput("areset_strobe", 32'(sample_strobe), 32'sd0);
        checkOutput("areset_running", 32'(running), 32'sd0);
        checkOutput("areset_level", 32'(level), 32'sd0);
        checkOutput("areset_ready", 32'(tbIf.s_ready), 32'sd0);
        #1 reset = 1'b0;
        startCount = cycleCount;
        pushRange(401, 16);
        waitStrobe("areset_restart_strobe", seen);
        checkOutput("areset_restart_cycles", 32'(cycleCount - startCount), 32'(Period));
        checkOutput("areset_restart_out_i", 32'(out_i), 32'sd401);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
